// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, the write-back port, the pipeline
// controls and the registered EX-stage outputs, grouped as one bundle.
interface id_ex_stage_if #(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [31:0]       id_pc;
   logic [4:0]        id_rs1;
   logic [4:0]        id_rs2;
   logic [4:0]        id_rd;
   logic [31:0]       id_imm;
   logic [31:0]       id_rd_d1;
   logic [31:0]       id_rd_d2;
   logic              id_mem_read;
   logic              id_reg_write;
   logic [CTRL_W-1:0] id_ctrl;
   logic              wb_reg_write;
   logic [4:0]        wb_rd;
   logic [31:0]       wb_data;
   logic              ex_hold;
   logic              ex_flush;
   logic              stall_id;
   logic              ex_valid;
   logic [31:0]       ex_pc;
   logic [4:0]        ex_rs1;
   logic [4:0]        ex_rs2;
   logic [4:0]        ex_rd;
   logic [31:0]       ex_imm;
   logic [31:0]       ex_op1;
   logic [31:0]       ex_op2;
   logic              ex_mem_read;
   logic              ex_reg_write;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [CNT_W-1:0]  bubble_cnt;

   // Upstream/control side: drives ID, WB and pipeline control, observes EX.
   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_rd_d1, id_rd_d2,
             id_mem_read, id_reg_write, id_ctrl, wb_reg_write, wb_rd, wb_data,
             ex_hold, ex_flush,
      input  stall_id, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_op1,
             ex_op2, ex_mem_read, ex_reg_write, ex_ctrl, bubble_cnt
   );

   // Stage side: consumes ID, WB and control, produces the EX register.
   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_rd_d1, id_rd_d2,
             id_mem_read, id_reg_write, id_ctrl, wb_reg_write, wb_rd, wb_data,
             ex_hold, ex_flush,
      output stall_id, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_op1,
             ex_op2, ex_mem_read, ex_reg_write, ex_ctrl, bubble_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the five-stage RISC-V core. Captures the decoded
// instruction, bypasses the same-cycle register-file write into the operands,
// inserts one bubble per load-use hazard, squashes on branch flush and counts
// every bubble it inserts.
module id_ex_stage #(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input logic           clk,
   input logic           rst_n,
   id_ex_stage_if.slave  bus
);

   logic              r_ex_valid;
   logic [31:0]       r_ex_pc;
   logic [4:0]        r_ex_rs1;
   logic [4:0]        r_ex_rs2;
   logic [4:0]        r_ex_rd;
   logic [31:0]       r_ex_imm;
   logic [31:0]       r_ex_op1;
   logic [31:0]       r_ex_op2;
   logic              r_ex_mem_read;
   logic              r_ex_reg_write;
   logic [CTRL_W-1:0] r_ex_ctrl;
   logic [CNT_W-1:0]  r_bubble_cnt;

   logic [31:0]       w_byp1;
   logic [31:0]       w_byp2;
   logic              w_luh;
   logic              w_stall_id;

   // The register file is written on the same edge the EX register captures,
   // so a matching write must be forwarded; x0 is never forwarded.
   function automatic logic [31:0] f_bypass(
      input logic        we,
      input logic [4:0]  wrd,
      input logic [31:0] wdata,
      input logic [4:0]  rs,
      input logic [31:0] rdata
   );
      logic [31:0] v;
      if (we && (wrd != 5'd0) && (wrd == rs)) begin
         v = wdata;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   // Operand bypass, load-use detection (index match only) and ID stall.
   always_comb begin
      w_byp1     = f_bypass(bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.id_rs1, bus.id_rd_d1);
      w_byp2     = f_bypass(bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.id_rs2, bus.id_rd_d2);
      w_luh      = 1'b0;
      w_stall_id = 1'b0;
      if (bus.id_valid && r_ex_valid && r_ex_mem_read && (r_ex_rd != 5'd0)) begin
         w_luh = (r_ex_rd == bus.id_rs1) || (r_ex_rd == bus.id_rs2);
      end else begin
         w_luh = 1'b0;
      end
      if (bus.ex_flush) begin
         w_stall_id = 1'b0;
      end else begin
         w_stall_id = bus.ex_hold || w_luh;
      end
   end

   // EX register: flush beats hold, hold beats load-use, otherwise capture ID.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid     <= 1'b0;
         r_ex_pc        <= 32'd0;
         r_ex_rs1       <= 5'd0;
         r_ex_rs2       <= 5'd0;
         r_ex_rd        <= 5'd0;
         r_ex_imm       <= 32'd0;
         r_ex_op1       <= 32'd0;
         r_ex_op2       <= 32'd0;
         r_ex_mem_read  <= 1'b0;
         r_ex_reg_write <= 1'b0;
         r_ex_ctrl      <= {CTRL_W{1'b0}};
         r_bubble_cnt   <= {CNT_W{1'b0}};
      end else if (bus.ex_flush || (!bus.ex_hold && w_luh)) begin
         r_ex_valid     <= 1'b0;
         r_ex_pc        <= 32'd0;
         r_ex_rs1       <= 5'd0;
         r_ex_rs2       <= 5'd0;
         r_ex_rd        <= 5'd0;
         r_ex_imm       <= 32'd0;
         r_ex_op1       <= 32'd0;
         r_ex_op2       <= 32'd0;
         r_ex_mem_read  <= 1'b0;
         r_ex_reg_write <= 1'b0;
         r_ex_ctrl      <= {CTRL_W{1'b0}};
         r_bubble_cnt   <= r_bubble_cnt + CNT_W'(1);
      end else if (bus.ex_hold) begin
         // Downstream stall: every EX field and the counter keep their value.
         r_bubble_cnt   <= r_bubble_cnt;
      end else begin
         r_ex_valid     <= bus.id_valid;
         r_ex_pc        <= bus.id_pc;
         r_ex_rs1       <= bus.id_rs1;
         r_ex_rs2       <= bus.id_rs2;
         r_ex_rd        <= bus.id_rd;
         r_ex_imm       <= bus.id_imm;
         r_ex_op1       <= w_byp1;
         r_ex_op2       <= w_byp2;
         r_ex_mem_read  <= bus.id_valid & bus.id_mem_read;
         r_ex_reg_write <= bus.id_valid & bus.id_reg_write;
         r_ex_ctrl      <= bus.id_valid ? bus.id_ctrl : {CTRL_W{1'b0}};
      end
   end

   assign bus.stall_id     = w_stall_id;
   assign bus.ex_valid     = r_ex_valid;
   assign bus.ex_pc        = r_ex_pc;
   assign bus.ex_rs1       = r_ex_rs1;
   assign bus.ex_rs2       = r_ex_rs2;
   assign bus.ex_rd        = r_ex_rd;
   assign bus.ex_imm       = r_ex_imm;
   assign bus.ex_op1       = r_ex_op1;
   assign bus.ex_op2       = r_ex_op2;
   assign bus.ex_mem_read  = r_ex_mem_read;
   assign bus.ex_reg_write = r_ex_reg_write;
   assign bus.ex_ctrl      = r_ex_ctrl;
   assign bus.bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic, all compared against a register-file-level reference model.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] op1;
      logic [31:0] op2;
      logic        mem_read;
      logic        reg_write;
      logic [7:0]  ctrl;
   } ex_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   ex_t         exp_m;
   int unsigned exp_cnt;
   logic [31:0] regs [32];

   id_ex_stage_if #(.CTRL_W(8), .CNT_W(16)) bus  ();
   id_ex_stage_if #(.CTRL_W(8), .CNT_W(4))  bus2 ();

   id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   id_ex_stage #(.CTRL_W(8), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ex_t dut_state();
      ex_t s;
      s.valid = bus.ex_valid;   s.pc = bus.ex_pc;     s.rs1 = bus.ex_rs1;
      s.rs2 = bus.ex_rs2;       s.rd = bus.ex_rd;     s.imm = bus.ex_imm;
      s.op1 = bus.ex_op1;       s.op2 = bus.ex_op2;   s.mem_read = bus.ex_mem_read;
      s.reg_write = bus.ex_reg_write;                 s.ctrl = bus.ex_ctrl;
      return s;
   endfunction

   // Value an instruction must see for register idx: the register file after
   // this cycle's write-back has landed (x0 is hard-wired zero).
   function automatic logic [31:0] reg_after_wb(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_data;
      return regs[idx];
   endfunction

   function automatic logic model_luh();
      return bus.id_valid && exp_m.valid && exp_m.mem_read && exp_m.rd != 5'd0 &&
             (exp_m.rd == bus.id_rs1 || exp_m.rd == bus.id_rs2);
   endfunction

   function automatic logic model_stall();
      return !bus.ex_flush && (bus.ex_hold || model_luh());
   endfunction

   task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
      bus.wb_reg_write = we; bus.wb_rd = rd; bus.wb_data = data;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                        input logic mr, input logic rw, input logic [7:0] ctrl);
      bus.id_valid = v;  bus.id_pc = pc;   bus.id_rs1 = rs1; bus.id_rs2 = rs2;
      bus.id_rd = rd;    bus.id_imm = imm; bus.id_mem_read = mr;
      bus.id_reg_write = rw; bus.id_ctrl = ctrl;
      bus.id_rd_d1 = regs[rs1]; bus.id_rd_d2 = regs[rs2];
      #1;
   endtask

   // One clock edge: predict the EX register and counter, then commit WB.
   task automatic tick();
      ex_t         nxt;
      int unsigned ncnt;
      logic        we;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      nxt = exp_m; ncnt = exp_cnt;
      we = bus.wb_reg_write; wrd = bus.wb_rd; wdat = bus.wb_data;
      if (bus.ex_flush || (!bus.ex_hold && model_luh())) begin
         nxt = '0;
         ncnt = ncnt + 1;
      end else if (!bus.ex_hold) begin
         nxt.valid = bus.id_valid; nxt.pc = bus.id_pc; nxt.rs1 = bus.id_rs1;
         nxt.rs2 = bus.id_rs2; nxt.rd = bus.id_rd; nxt.imm = bus.id_imm;
         nxt.op1 = reg_after_wb(bus.id_rs1);
         nxt.op2 = reg_after_wb(bus.id_rs2);
         nxt.mem_read  = bus.id_valid && bus.id_mem_read;
         nxt.reg_write = bus.id_valid && bus.id_reg_write;
         nxt.ctrl      = bus.id_valid ? bus.id_ctrl : 8'h00;
      end
      @(posedge clk);
      #1;
      if (we && wrd != 5'd0) regs[wrd] = wdat;
      exp_m = nxt; exp_cnt = ncnt;
   endtask

   task automatic test_reset();
      ex_t got;
      rst_n = 1'b0;
      bus.ex_hold = 1'b1; bus.ex_flush = 1'b0;
      set_wb(1'b0, 5'd0, 32'd0);
      drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 8'h00);
      #2;
      got = dut_state();
      if (got !== ex_t'(0)) begin $display("FAIL reset_state: got %h want 0", got); errors++; end
      checks++;
      if (bus.bubble_cnt !== 16'd0) begin $display("FAIL reset_cnt: got %0d want 0", bus.bubble_cnt); errors++; end
      checks++;
      if (bus.stall_id !== 1'b1) begin $display("FAIL reset_stall_hold: got %b want 1", bus.stall_id); errors++; end
      checks++;
      bus.ex_hold = 1'b0;
      #1;
      if (bus.stall_id !== 1'b0) begin $display("FAIL reset_stall_nohold: got %b want 0", bus.stall_id); errors++; end
      checks++;
      #4 rst_n = 1'b1;
      exp_m = '0; exp_cnt = 0;
      tick();
   endtask

   task automatic test_bypass();
      ex_t got;
      regs[5] = 32'd0;
      set_wb(1'b1, 5'd5, 32'hDEADBEEF);
      drive(1'b1, 32'h100, 5'd5, 5'd6, 5'd10, 32'h4, 1'b0, 1'b1, 8'h3C);
      tick();
      got = dut_state();
      if (bus.ex_op1 !== 32'hDEADBEEF || got !== exp_m) begin
         $display("FAIL bypass_rs1: got %h want %h", got, exp_m); errors++;
      end
      checks++;
      set_wb(1'b1, 5'd0, 32'h12345678);
      drive(1'b1, 32'h104, 5'd0, 5'd5, 5'd11, 32'h8, 1'b0, 1'b1, 8'h01);
      tick();
      got = dut_state();
      if (bus.ex_op1 !== 32'd0 || got !== exp_m) begin
         $display("FAIL bypass_x0: got %h want %h", got, exp_m); errors++;
      end
      checks++;
      set_wb(1'b1, 5'd9, 32'hA5A5_0F0F);
      drive(1'b1, 32'h108, 5'd9, 5'd9, 5'd12, 32'h0, 1'b0, 1'b1, 8'h02);
      tick();
      got = dut_state();
      if (bus.ex_op1 !== 32'hA5A5_0F0F || bus.ex_op2 !== 32'hA5A5_0F0F || got !== exp_m) begin
         $display("FAIL bypass_both: got %h want %h", got, exp_m); errors++;
      end
      checks++;
      set_wb(1'b0, 5'd5, 32'h0BAD_F00D);
      drive(1'b1, 32'h10C, 5'd5, 5'd3, 5'd13, 32'h0, 1'b0, 1'b1, 8'h04);
      tick();
      got = dut_state();
      if (bus.ex_op1 !== 32'hDEADBEEF || got !== exp_m) begin
         $display("FAIL bypass_no_we: got %h want %h", got, exp_m); errors++;
      end
      checks++;
   endtask

   task automatic test_load_use();
      ex_t         got;
      int unsigned cnt0;
      set_wb(1'b0, 5'd0, 32'd0);
      drive(1'b1, 32'h200, 5'd2, 5'd0, 5'd7, 32'h10, 1'b1, 1'b1, 8'h11);
      tick();
      cnt0 = exp_cnt;
      drive(1'b1, 32'h204, 5'd3, 5'd7, 5'd8, 32'h0, 1'b0, 1'b1, 8'h22);
      if (bus.stall_id !== 1'b1 || model_stall() !== 1'b1) begin
         $display("FAIL luh_stall: got %b want 1", bus.stall_id); errors++;
      end
      checks++;
      tick();
      got = dut_state();
      if (bus.ex_valid !== 1'b0 || got !== exp_m || bus.bubble_cnt !== 16'(cnt0 + 1)) begin
         $display("FAIL luh_bubble: got %h cnt %0d want %h cnt %0d", got, bus.bubble_cnt, exp_m, cnt0 + 1);
         errors++;
      end
      checks++;
      if (bus.stall_id !== 1'b0) begin $display("FAIL luh_release: got %b want 0", bus.stall_id); errors++; end
      checks++;
      tick();
      got = dut_state();
      if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h204 || got !== exp_m) begin
         $display("FAIL luh_advance: got %h want %h", got, exp_m); errors++;
      end
      checks++;
   endtask

   task automatic test_flush_priority();
      ex_t         got;
      int unsigned cnt0;
      drive(1'b1, 32'h300, 5'd1, 5'd1, 5'd7, 32'h0, 1'b1, 1'b1, 8'h33);
      tick();
      cnt0 = exp_cnt;
      bus.ex_hold = 1'b1; bus.ex_flush = 1'b1;
      drive(1'b1, 32'h304, 5'd7, 5'd4, 5'd9, 32'h0, 1'b0, 1'b1, 8'h44);
      if (bus.stall_id !== 1'b0) begin $display("FAIL flush_stall: got %b want 0", bus.stall_id); errors++; end
      checks++;
      tick();
      got = dut_state();
      if (got !== ex_t'(0) || got !== exp_m || bus.bubble_cnt !== 16'(cnt0 + 1)) begin
         $display("FAIL flush_bubble: got %h cnt %0d want 0 cnt %0d", got, bus.bubble_cnt, cnt0 + 1);
         errors++;
      end
      checks++;
      bus.ex_hold = 1'b0; bus.ex_flush = 1'b0;
   endtask

   task automatic test_hold();
      ex_t         got;
      ex_t         snap;
      int unsigned cnt0;
      drive(1'b1, 32'h400, 5'd4, 5'd5, 5'd6, 32'h77, 1'b0, 1'b1, 8'h55);
      tick();
      snap = exp_m; cnt0 = exp_cnt;
      bus.ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
         if (bus.stall_id !== 1'b1) begin $display("FAIL hold_stall: got %b want 1", bus.stall_id); errors++; end
         checks++;
         tick();
         got = dut_state();
         if (got !== snap || bus.bubble_cnt !== 16'(cnt0)) begin
            $display("FAIL hold_frozen: got %h cnt %0d want %h cnt %0d", got, bus.bubble_cnt, snap, cnt0);
            errors++;
         end
         checks++;
      end
      bus.ex_hold = 1'b0;
   endtask

   task automatic test_random();
      ex_t got;
      for (int i = 0; i < 400; i++) begin
         set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         bus.ex_hold  = ($urandom_range(0, 9) == 0);
         bus.ex_flush = ($urandom_range(0, 11) == 0);
         drive(($urandom_range(0, 4) != 0), $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               8'($urandom));
         if (bus.stall_id !== model_stall()) begin
            $display("FAIL rand_stall[%0d]: got %b want %b", i, bus.stall_id, model_stall()); errors++;
         end
         checks++;
         tick();
         got = dut_state();
         if (got !== exp_m || bus.bubble_cnt !== 16'(exp_cnt)) begin
            $display("FAIL rand_ex[%0d]: got %h cnt %0d want %h cnt %0d", i, got, bus.bubble_cnt, exp_m, exp_cnt[15:0]);
            errors++;
         end
         checks++;
      end
      bus.ex_hold = 1'b0; bus.ex_flush = 1'b0;
      set_wb(1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_async_reset();
      ex_t got;
      drive(1'b1, 32'h500, 5'd1, 5'd2, 5'd7, 32'h9, 1'b1, 1'b1, 8'h66);
      tick();
      #2 rst_n = 1'b0;
      #1;
      got = dut_state();
      if (got !== ex_t'(0) || bus.bubble_cnt !== 16'd0) begin
         $display("FAIL async_reset: got %h cnt %0d want 0 cnt 0", got, bus.bubble_cnt); errors++;
      end
      checks++;
      bus.ex_hold = 1'b1;
      drive(1'b1, 32'h504, 5'd7, 5'd7, 5'd3, 32'h0, 1'b0, 1'b1, 8'h00);
      if (bus.stall_id !== 1'b1) begin $display("FAIL async_reset_stall: got %b want 1", bus.stall_id); errors++; end
      checks++;
      bus.ex_hold = 1'b0;
      #2 rst_n = 1'b1;
      exp_m = '0; exp_cnt = 0;
      tick();
      got = dut_state();
      if (bus.ex_pc !== 32'h504 || got !== exp_m) begin
         $display("FAIL async_reset_resume: got %h want %h", got, exp_m); errors++;
      end
      checks++;
   endtask

   task automatic test_wrap();
      bus2.ex_flush = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 16 || k == 17) begin
            if (bus2.bubble_cnt !== 4'(k % 16)) begin
               $display("FAIL cnt_wrap[%0d]: got %0d want %0d", k, bus2.bubble_cnt, k % 16); errors++;
            end
            checks++;
         end
      end
      bus2.ex_flush = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      regs[0] = 32'd0;
      for (int r = 1; r < 32; r++) regs[r] = $urandom;
      bus2.id_valid = 1'b0; bus2.id_pc = 32'd0; bus2.id_rs1 = 5'd0; bus2.id_rs2 = 5'd0;
      bus2.id_rd = 5'd0; bus2.id_imm = 32'd0; bus2.id_rd_d1 = 32'd0; bus2.id_rd_d2 = 32'd0;
      bus2.id_mem_read = 1'b0; bus2.id_reg_write = 1'b0; bus2.id_ctrl = 8'h00;
      bus2.wb_reg_write = 1'b0; bus2.wb_rd = 5'd0; bus2.wb_data = 32'd0;
      bus2.ex_hold = 1'b0; bus2.ex_flush = 1'b0;
      test_reset();
      test_bypass();
      test_load_use();
      test_flush_priority();
      test_hold();
      test_random();
      test_async_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage RISC-V core. It sits directly downstream of the register file read ports and captures each decoded instruction's operands and control into the EX-stage register. It also performs:
- write-back-to-decode bypass, so a value being written this cycle is seen by the instruction reading it;
- load-use hazard detection with bubble insertion;
- branch flush;
- a bubble performance counter.

## Interface
Parameters:
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_pc  in  32  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices; also drive the register file read addresses
- id_imm  in  32  decoded immediate
- id_rd_d1, id_rd_d2  in  32 each  register file read data for rs1 and rs2
- id_mem_read  in  1  instruction is a load
- id_reg_write  in  1  instruction writes rd
- id_ctrl  in  CTRL_W  remaining control, passed through unchanged
- wb_reg_write, wb_rd, wb_data  in  1/5/32  same signals that drive the register file write port
- ex_hold  in  1  downstream stall; freeze the EX register
- ex_flush  in  1  taken branch or jump resolved in EX; squash the ID instruction
- stall_id  out  1  hold the PC and IF/ID registers this cycle
- ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm  out  1/32/5/5/5/32  registered copies of the ID fields
- ex_op1, ex_op2  out  32 each  registered operands, after bypass
- ex_mem_read, ex_reg_write, ex_ctrl  out  1/1/CTRL_W  registered control
- bubble_cnt  out  CNT_W  count of bubbles inserted

## Operation
Bypass (combinational, computed in ID):
- byp1 = wb_data if wb_reg_write && wb_rd!=0 && wb_rd==id_rs1; otherwise id_rd_d1.
- byp2 is formed the same way from id_rs2 and id_rd_d2.

Load-use hazard (combinational):
- luh = id_valid && ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- The match is on index only; whether the instruction actually uses rs2 is not considered.

stall_id = !ex_flush && (ex_hold || luh).

EX register update on each edge, first matching rule wins:
1. ex_flush: load a bubble.
2. ex_hold: keep all EX fields unchanged.
3. luh: load a bubble.
4. Otherwise: load the ID fields, with ex_op1=byp1, ex_op2=byp2, ex_valid=id_valid.

Bubble definition:
- ex_valid=0, ex_mem_read=0, ex_reg_write=0, ex_ctrl=0.
- ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_op1 and ex_op2 are all zeroed.

Valid gating: when id_valid=0 under rule 4, ex_mem_read, ex_reg_write and ex_ctrl are forced to 0.

bubble_cnt:
- Increments by 1 on every edge where rule 1 or rule 3 applies.
- Wraps modulo 2^CNT_W.

## Timing
Reset:
- rst_n low clears every EX output and bubble_cnt to 0 immediately, without waiting for a clock edge.
- stall_id then depends only on ex_hold.
- Deassertion takes effect on the next rising edge.
- Reset during a stall or hold discards the held instruction; no replay.

Latency and logic depth:
- ID to EX is one cycle.
- stall_id and the bypass are combinational and settle within the same cycle.

Load-use:
- Exactly one bubble per hazard.
- On the following cycle the load has moved to MEM, so luh clears and the held ID instruction advances.

Simultaneous events:
- ex_flush overrides ex_hold and luh; stall_id=0 that cycle.
- A WB write to the same register as a load-use match: the bypass still applies to byp1/byp2, but luh forces a bubble anyway.
- A WB write to x0 is never bypassed; an instruction reading x0 receives id_rd_d1 or id_rd_d2 (0).
- Both rs1 and rs2 matching wb_rd: both operands take wb_data.

## Test plan
- Reset: assert rst_n=0 mid-cycle with ex_valid=1 -> all EX outputs and bubble_cnt read 0 before the next edge.
- Bypass: WB writes x5=0xDEADBEEF while the regfile reads x5 as 0 for id_rs1=5 -> ex_op1=0xDEADBEEF next cycle; repeat with wb_rd=0 -> ex_op1=id_rd_d1.
- Load-use: an lw into x7 sits in EX, ID holds an add reading x7 as rs2:
  - stall_id=1 for exactly one cycle;
  - EX then holds a bubble (ex_valid=0);
  - the add enters EX on the next cycle;
  - bubble_cnt=1.
- Flush priority: ex_flush=1 together with ex_hold=1 and a luh condition -> stall_id=0, EX holds a bubble next cycle, bubble_cnt increments by 1.
- Hold: ex_hold=1 for 3 cycles with changing ID inputs -> EX outputs are unchanged for 3 cycles, stall_id=1 throughout, bubble_cnt is unchanged.
- Counter wrap: CNT_W=4 with 17 consecutive flushes -> bubble_cnt=1.
